// File: rtl/load_store_unit_if.sv
// Request/response handshake plus the word-memory port of the load/store unit.
// The slave modport is the unit's view; master is the requester plus memory side.
interface load_store_unit_if;
    // Request channel
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;

    // Response channel
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_fault;

    // 64-bit word memory: combinational read, posedge write
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    modport slave (
        input  req_valid,
        input  req_write,
        input  req_funct3,
        input  req_addr,
        input  req_wdata,
        input  mem_rdata,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output resp_fault,
        output mem_read,
        output mem_write,
        output mem_addr,
        output mem_wdata
    );

    modport master (
        output req_valid,
        output req_write,
        output req_funct3,
        output req_addr,
        output req_wdata,
        output mem_rdata,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  resp_fault,
        input  mem_read,
        input  mem_write,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit for a 64-bit word memory.
// Loads take one memory read; sub-word stores do read-modify-write; doubleword
// stores write directly. Misaligned or illegal requests fault without touching memory.
module load_store_unit (
    input logic              clk,
    input logic              rst_n,
    load_store_unit_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StLd,
        StStRd,
        StStWr,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] old_q, old_d;
    logic [63:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;

    logic        req_fault;
    logic [5:0]  lane_shift;
    logic [63:0] word_addr;
    logic [63:0] ld_shifted;
    logic [63:0] ld_ext;
    logic [63:0] lane_mask;
    logic [63:0] st_merged;

    assign lane_shift = {addr_q[2:0], 3'b000};
    assign word_addr  = {addr_q[63:3], 3'b000};

    // Fault decode on the live request: alignment per access size, plus illegal codes
    always_comb begin
        req_fault = 1'b0;
        case (bus.req_funct3[1:0])
            2'b01:   req_fault = bus.req_addr[0];
            2'b10:   req_fault = |bus.req_addr[1:0];
            2'b11:   req_fault = |bus.req_addr[2:0];
            default: req_fault = 1'b0;
        endcase
        if (bus.req_write && bus.req_funct3[2]) begin
            req_fault = 1'b1;
        end
        if (!bus.req_write && (bus.req_funct3 == 3'b111)) begin
            req_fault = 1'b1;
        end
    end

    // Load path: align the addressed lane to bit 0 and extend per width code
    always_comb begin
        ld_shifted = bus.mem_rdata >> lane_shift;
        ld_ext     = 64'h0;
        case (funct3_q)
            3'b000:  ld_ext = {{56{ld_shifted[7]}}, ld_shifted[7:0]};
            3'b001:  ld_ext = {{48{ld_shifted[15]}}, ld_shifted[15:0]};
            3'b010:  ld_ext = {{32{ld_shifted[31]}}, ld_shifted[31:0]};
            3'b011:  ld_ext = ld_shifted;
            3'b100:  ld_ext = {56'h0, ld_shifted[7:0]};
            3'b101:  ld_ext = {48'h0, ld_shifted[15:0]};
            3'b110:  ld_ext = {32'h0, ld_shifted[31:0]};
            default: ld_ext = 64'h0;
        endcase
    end

    // Store path: splice the low bytes of the store data into the old word
    always_comb begin
        case (funct3_q[1:0])
            2'b00:   lane_mask = 64'h0000_0000_0000_00ff;
            2'b01:   lane_mask = 64'h0000_0000_0000_ffff;
            default: lane_mask = 64'h0000_0000_ffff_ffff;
        endcase
        st_merged = (old_q & ~(lane_mask << lane_shift)) | ((wdata_q & lane_mask) << lane_shift);
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        old_d    = old_q;
        rdata_d  = rdata_q;
        fault_d  = fault_q;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    rdata_d  = 64'h0;
                    fault_d  = req_fault;
                    // Load/store direction is carried by the state from here on
                    if (req_fault) begin
                        state_d = StResp;
                    end else if (!bus.req_write) begin
                        state_d = StLd;
                    end else if (bus.req_funct3[1:0] == 2'b11) begin
                        state_d = StStWr;
                    end else begin
                        state_d = StStRd;
                    end
                end
            end
            StLd: begin
                rdata_d = ld_ext;
                state_d = StResp;
            end
            StStRd: begin
                old_d   = bus.mem_rdata;
                state_d = StStWr;
            end
            StStWr: begin
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and captured-request registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            funct3_q <= 3'b000;
            addr_q   <= 64'h0;
            wdata_q  <= 64'h0;
            old_q    <= 64'h0;
            rdata_q  <= 64'h0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            old_q    <= old_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
        end
    end

    // Outputs decoded from state only
    always_comb begin
        bus.req_ready  = (state_q == StIdle);
        bus.resp_valid = (state_q == StResp);
        bus.resp_fault = (state_q == StResp) && fault_q;
        bus.resp_rdata = rdata_q;
        bus.mem_read   = (state_q == StLd) || (state_q == StStRd);
        bus.mem_write  = (state_q == StStWr);
        bus.mem_addr   = 64'h0;
        bus.mem_wdata  = 64'h0;
        if ((state_q == StLd) || (state_q == StStRd) || (state_q == StStWr)) begin
            bus.mem_addr = word_addr;
        end
        if (state_q == StStWr) begin
            bus.mem_wdata = (funct3_q[1:0] == 2'b11) ? wdata_q : st_merged;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table of single operations against a
// preloaded word at 0x10, plus cycle-exact sequences for store timing, reset abort
// and back-to-back acceptance.
module tb_load_store_unit;

    localparam logic [63:0] Init = 64'h8877_6655_4433_2211;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    load_store_unit_if bus ();

    load_store_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory: combinational read, posedge write, with a bench preload port
    logic [63:0] mem [0:15];
    logic        pre_en;
    logic [63:0] pre_val;

    assign bus.mem_rdata = mem[bus.mem_addr[6:3]];

    always @(posedge clk) begin
        if (pre_en) begin
            mem[2] <= pre_val;
        end else if (bus.mem_write) begin
            mem[bus.mem_addr[6:3]] <= bus.mem_wdata;
        end
    end

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        fault;
        logic [63:0] rdata;
        int          lat;
        logic        rd_seen;
        logic        wr_seen;
        logic [63:0] word;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [63:0] val);
        pre_en  = 1'b1;
        pre_val = val;
        @(posedge clk);
        #1;
        pre_en = 1'b0;
    endtask

    task automatic drive_req(input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                             input logic [63:0] wdata);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
    endtask

    // Scramble request fields after acceptance; the unit must not look at them
    task automatic junk_req();
        bus.req_valid  = 1'b0;
        bus.req_write  = ~bus.req_write;
        bus.req_funct3 = 3'b111;
        bus.req_addr   = 64'hffff_ffff_ffff_ffff;
        bus.req_wdata  = 64'h5a5a_5a5a_5a5a_5a5a;
    endtask

    // Issue one operation (starting just after a posedge) and watch it to completion
    task automatic run_op(input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] wdata, output logic ready0, output int lat,
                          output logic [63:0] rdata, output logic fault,
                          output logic rd_seen, output logic wr_seen);
        logic done;
        drive_req(wr, f3, addr, wdata);
        @(negedge clk);
        ready0 = bus.req_ready;
        @(posedge clk);
        #1;
        junk_req();
        lat     = 0;
        rdata   = '0;
        fault   = 1'b0;
        rd_seen = 1'b0;
        wr_seen = 1'b0;
        done    = 1'b0;
        for (int c = 1; (c <= 6) && !done; c++) begin
            @(negedge clk);
            if (bus.mem_read)  rd_seen = 1'b1;
            if (bus.mem_write) wr_seen = 1'b1;
            if (bus.resp_valid) begin
                lat   = c;
                rdata = bus.resp_rdata;
                fault = bus.resp_fault;
                done  = 1'b1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic        ready0;
        int          lat;
        logic [63:0] rdata;
        logic        fault;
        logic        rd_seen;
        logic        wr_seen;
        logic        rv_seen;
        logic [5:0]  exp_rdy;
        logic [5:0]  exp_rv;

        // wr, f3, addr, wdata, fault, rdata, lat, rd, wr, word-after
        vecs[0]  = '{1'b0, 3'b000, 64'h17, 64'h0, 1'b0, 64'hffff_ffff_ffff_ff88, 2, 1'b1, 1'b0, Init};
        vecs[1]  = '{1'b0, 3'b100, 64'h17, 64'h0, 1'b0, 64'h0000_0000_0000_0088, 2, 1'b1, 1'b0, Init};
        vecs[2]  = '{1'b0, 3'b010, 64'h14, 64'h0, 1'b0, 64'hffff_ffff_8877_6655, 2, 1'b1, 1'b0, Init};
        vecs[3]  = '{1'b0, 3'b110, 64'h14, 64'h0, 1'b0, 64'h0000_0000_8877_6655, 2, 1'b1, 1'b0, Init};
        vecs[4]  = '{1'b0, 3'b001, 64'h12, 64'h0, 1'b0, 64'h0000_0000_0000_4433, 2, 1'b1, 1'b0, Init};
        vecs[5]  = '{1'b0, 3'b001, 64'h16, 64'h0, 1'b0, 64'hffff_ffff_ffff_8877, 2, 1'b1, 1'b0, Init};
        vecs[6]  = '{1'b0, 3'b101, 64'h16, 64'h0, 1'b0, 64'h0000_0000_0000_8877, 2, 1'b1, 1'b0, Init};
        vecs[7]  = '{1'b0, 3'b011, 64'h10, 64'h0, 1'b0, Init, 2, 1'b1, 1'b0, Init};
        vecs[8]  = '{1'b0, 3'b000, 64'h10, 64'h0, 1'b0, 64'h0000_0000_0000_0011, 2, 1'b1, 1'b0, Init};
        vecs[9]  = '{1'b1, 3'b011, 64'h10, 64'h0123_4567_89ab_cdef, 1'b0, 64'h0, 2, 1'b0, 1'b1,
                     64'h0123_4567_89ab_cdef};
        vecs[10] = '{1'b1, 3'b001, 64'h12, 64'h1234_5678_9abc_beef, 1'b0, 64'h0, 3, 1'b1, 1'b1,
                     64'h8877_6655_beef_2211};
        vecs[11] = '{1'b1, 3'b000, 64'h15, 64'hffff_ffff_ffff_ffa5, 1'b0, 64'h0, 3, 1'b1, 1'b1,
                     64'h8877_a555_4433_2211};
        vecs[12] = '{1'b1, 3'b010, 64'h14, 64'h0000_0000_dead_beef, 1'b0, 64'h0, 3, 1'b1, 1'b1,
                     64'hdead_beef_4433_2211};
        vecs[13] = '{1'b0, 3'b010, 64'h16, 64'h0, 1'b1, 64'h0, 1, 1'b0, 1'b0, Init};
        vecs[14] = '{1'b0, 3'b111, 64'h10, 64'h0, 1'b1, 64'h0, 1, 1'b0, 1'b0, Init};
        vecs[15] = '{1'b0, 3'b001, 64'h11, 64'h0, 1'b1, 64'h0, 1, 1'b0, 1'b0, Init};
        vecs[16] = '{1'b1, 3'b011, 64'h14, 64'hffff, 1'b1, 64'h0, 1, 1'b0, 1'b0, Init};
        vecs[17] = '{1'b1, 3'b100, 64'h10, 64'hffff, 1'b1, 64'h0, 1, 1'b0, 1'b0, Init};

        n_checks       = 0;
        n_fail         = 0;
        pre_en         = 1'b0;
        pre_val        = '0;
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("reset req_ready", 64'(bus.req_ready), 64'h1);
        check("reset resp_valid", 64'(bus.resp_valid), 64'h0);
        check("reset resp_rdata", bus.resp_rdata, 64'h0);
        check("reset resp_fault", 64'(bus.resp_fault), 64'h0);
        check("reset mem_read", 64'(bus.mem_read), 64'h0);
        check("reset mem_write", 64'(bus.mem_write), 64'h0);
        check("reset mem_addr", bus.mem_addr, 64'h0);
        check("reset mem_wdata", bus.mem_wdata, 64'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven single operations
        for (int i = 0; i < 18; i++) begin
            preload(Init);
            run_op(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                   ready0, lat, rdata, fault, rd_seen, wr_seen);
            check($sformatf("vec%0d ready", i), 64'(ready0), 64'h1);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("vec%0d rdata", i), rdata, vecs[i].rdata);
            check($sformatf("vec%0d fault", i), 64'(fault), 64'(vecs[i].fault));
            check($sformatf("vec%0d mem_read seen", i), 64'(rd_seen), 64'(vecs[i].rd_seen));
            check($sformatf("vec%0d mem_write seen", i), 64'(wr_seen), 64'(vecs[i].wr_seen));
            check($sformatf("vec%0d word", i), mem[2], vecs[i].word);
        end

        // SD cycle-exact: direct write at C1, response at C2
        preload(64'h0);
        drive_req(1'b1, 3'b011, 64'h10, Init);
        @(negedge clk);
        @(posedge clk);
        #1;
        junk_req();
        @(negedge clk);
        check("sd c1 mem_read", 64'(bus.mem_read), 64'h0);
        check("sd c1 mem_write", 64'(bus.mem_write), 64'h1);
        check("sd c1 mem_addr", bus.mem_addr, 64'h10);
        check("sd c1 mem_wdata", bus.mem_wdata, Init);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("sd c2 resp_valid", 64'(bus.resp_valid), 64'h1);
        check("sd c2 resp_fault", 64'(bus.resp_fault), 64'h0);
        @(posedge clk);
        #1;
        check("sd word", mem[2], Init);

        // SH cycle-exact: read at C1, merged write at C2, response at C3
        drive_req(1'b1, 3'b001, 64'h12, 64'h0000_0000_0000_beef);
        @(negedge clk);
        @(posedge clk);
        #1;
        junk_req();
        @(negedge clk);
        check("sh c1 mem_read", 64'(bus.mem_read), 64'h1);
        check("sh c1 mem_addr", bus.mem_addr, 64'h10);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("sh c2 mem_write", 64'(bus.mem_write), 64'h1);
        check("sh c2 mem_wdata", bus.mem_wdata, 64'h8877_6655_beef_2211);
        check("sh c2 resp_valid", 64'(bus.resp_valid), 64'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("sh c3 resp_valid", 64'(bus.resp_valid), 64'h1);
        @(posedge clk);
        #1;

        // Reset during ST_RD abandons the store
        preload(Init);
        drive_req(1'b1, 3'b000, 64'h10, 64'haa);
        @(negedge clk);
        @(posedge clk);
        #1;
        junk_req();
        @(negedge clk);
        check("rst st_rd mem_read", 64'(bus.mem_read), 64'h1);
        rst_n = 1'b0;
        #1;
        check("rst immediate req_ready", 64'(bus.req_ready), 64'h1);
        wr_seen = 1'b0;
        rv_seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (c == 2) rst_n = 1'b1;
            @(negedge clk);
            if (bus.mem_write)  wr_seen = 1'b1;
            if (bus.resp_valid) rv_seen = 1'b1;
        end
        check("rst mem_write seen", 64'(wr_seen), 64'h0);
        check("rst resp_valid seen", 64'(rv_seen), 64'h0);
        check("rst word unchanged", mem[2], Init);
        check("rst req_ready after release", 64'(bus.req_ready), 64'h1);
        @(posedge clk);
        #1;

        // Back-to-back with req_valid held high: accept, LD, RESP, accept, LD, RESP
        exp_rdy = 6'b001001;
        exp_rv  = 6'b100100;
        drive_req(1'b0, 3'b000, 64'h17, 64'h0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("b2b cyc%0d req_ready", k), 64'(bus.req_ready), 64'(exp_rdy[k]));
            check($sformatf("b2b cyc%0d resp_valid", k), 64'(bus.resp_valid), 64'(exp_rv[k]));
            if (k == 5) begin
                check("b2b second rdata", bus.resp_rdata, 64'hffff_ffff_ffff_ff88);
            end
            @(posedge clk);
            #1;
            if (k == 3) bus.req_valid = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-003 SHALL have port req_valid  input  1  request present.
REQ-004 SHALL have port req_ready  output  1  unit idle; request accepted when req_valid && req_ready at posedge.
REQ-005 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-006 SHALL have port req_funct3  input  3  RISC-V width code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
REQ-007 SHALL have port req_addr  input  64  byte address.
REQ-008 SHALL have port req_wdata  input  64  store data, right-aligned.
REQ-009 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL have port resp_rdata  output  64  extended load result; 0 for stores and faults.
REQ-011 SHALL have port resp_fault  output  1  misaligned or illegal funct3, valid with resp_valid.
REQ-012 SHALL have ports mem_read (output, 1), mem_write (output, 1), mem_addr (output, 64), mem_wdata (output, 64) and mem_rdata (input, 64), which drive a 64-bit word memory with combinational read and posedge write.

Function
REQ-013 SHALL capture funct3, write, addr and wdata at acceptance, so request inputs are don't-care afterwards.
REQ-014 SHALL use FSM states IDLE, LD, ST_RD, ST_WR and RESP; req_ready SHALL be 1 only in IDLE.
REQ-015 SHALL transition from IDLE on acceptance as follows: fault -> RESP; load -> LD; store D -> ST_WR; store B/H/W -> ST_RD.
REQ-016 SHALL transition LD -> RESP, ST_RD -> ST_WR, ST_WR -> RESP and RESP -> IDLE, each unconditionally.
REQ-017 SHALL decode mem_read = (state==LD || state==ST_RD) and mem_write = (state==ST_WR) from state only.
REQ-018 SHALL drive mem_addr = {addr[63:3],3'b000} from the captured address in LD, ST_RD and ST_WR, and 0 otherwise.
REQ-019 SHALL use little-endian byte lanes, with lane offset = addr[2:0]*8.
REQ-020 SHALL, in LD, register mem_rdata shifted right by the lane offset and sign- or zero-extended per funct3 into resp_rdata.
REQ-021 SHALL, in ST_RD, register mem_rdata as the old word.
REQ-022 SHALL, in ST_WR, drive mem_wdata = old word with the B/H/W lanes replaced by the low bytes of wdata; for D, mem_wdata = wdata.
REQ-023 SHALL assert resp_valid only in RESP, for exactly one cycle.
REQ-024 SHALL set fault when: H with addr[0]!=0; W with addr[1:0]!=0; D with addr[2:0]!=0; load funct3 111; store funct3[2]=1.
REQ-025 SHALL, on fault, perform no mem_read or mem_write, set resp_fault=1 and resp_rdata=0.
REQ-026 SHALL give latency from the acceptance cycle C0 to resp_valid as: fault C1; load C2; store D C2; store B/H/W C3.
REQ-027 SHALL ignore req_valid while not in IDLE, with no queuing.
REQ-028 SHALL allow back-to-back operation, so a new request is accepted in the IDLE cycle after RESP.

Reset
REQ-029 SHALL, when rst_n=0, immediately force the state to IDLE and all registers to 0.
REQ-030 SHALL produce these reset output values: req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
REQ-031 SHALL, on reset in any state, abandon the operation, so that no mem_write is issued after rst_n falls and no resp_valid occurs for that request.

Verification
REQ-032 SHALL verify: SD 0x8877665544332211 to 0x10 -> C1 mem_write=1, mem_addr=0x10, mem_wdata=0x8877665544332211; C2 resp_valid=1, resp_fault=0.
REQ-033 SHALL verify, with word@0x10=0x8877665544332211: LB 0x17 -> resp_rdata=0xFFFFFFFFFFFFFF88; LBU 0x17 -> 0x0000000000000088; LW 0x14 -> 0xFFFFFFFF88776655; LWU 0x14 -> 0x0000000088776655, each at C2.
REQ-034 SHALL verify: SH wdata=0xBEEF to 0x12 over the same word -> C1 mem_read=1; C2 mem_write=1, mem_wdata=0x88776655BEEF2211; C3 resp_valid=1.
REQ-035 SHALL verify: LW 0x16 and load funct3=111 -> C1 resp_valid=1, resp_fault=1, resp_rdata=0, with mem_read and mem_write never asserted.
REQ-036 SHALL verify: SB to 0x10 with rst_n pulsed low during ST_RD -> mem_write never asserted, the memory word is unchanged, and req_ready=1 after release.
REQ-037 SHALL verify: req_valid held high across two requests -> second accepted exactly one cycle after the first's RESP; req_ready=0 in every intervening cycle.
